// File: rtl/common.sv
// Shared fetch-path widths, FSM state type and parcel helpers.
// Imported by fetch_controller and parcel_buffer.
package common;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int DATA_WIDTH        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_type;

  // RISC-V encodes 32-bit instructions with 2'b11 in the low bits of the first parcel.
  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/parcel_buffer.sv
// Halfword parcel FIFO between instruction memory and decode; count is in halfwords.
// With COMPRESSED_EN: three 16-bit entries. Without: a single 32-bit word (count 0 or 2).
module parcel_buffer
  import common::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            push_cnt,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            pop_cnt,
  output logic [1:0]            count,
  output logic [31:0]           head
);

`ifdef COMPRESSED_EN
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [1:0]  count_mid;
  logic [1:0]  count_d;

  // Pop shifts toward entry 0, then pushes land right after the survivors;
  // a single-parcel push carries the upper halfword (redirect into mid-word).
  always_comb begin
    count_mid = count - pop_cnt;
    case (pop_cnt)
      2'd1:    hw_d = '{hw_q[1], hw_q[2], 16'h0};
      2'd2:    hw_d = '{hw_q[2], 16'h0, 16'h0};
      default: hw_d = hw_q;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (push_cnt == 2'd2 && i == int'(count_mid))     hw_d[i] = push_data[15:0];
      if (push_cnt == 2'd2 && i == int'(count_mid) + 1) hw_d[i] = push_data[31:16];
      if (push_cnt == 2'd1 && i == int'(count_mid))     hw_d[i] = push_data[31:16];
    end
    count_d = count_mid + push_cnt;
    if (flush) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q  <= '{default: 16'h0};
      count <= 2'd0;
    end else begin
      hw_q  <= hw_d;
      count <= count_d;
    end
  end

  assign head = {hw_q[1], hw_q[0]};
`else
  logic [31:0] word_q;

  // A new fetch is only issued once the word has been consumed, so push never meets a full entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (push_cnt != 2'd0) begin
      word_q <= push_data;
      count  <= 2'd2;
    end else if (pop_cnt != 2'd0) begin
      count <= 2'd0;
    end
  end

  assign head = word_q;
`endif

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: single-outstanding imem requests feeding a parcel buffer for decode.
// COMPRESSED_EN enables 16-bit parcels and halfword-aligned PCs; otherwise misaligned redirects pulse misalign_err.
//
// state | meaning
// IDLE  | one-cycle pause before requesting again
// REQ   | request fetch_pc once the buffer has room
// WAIT  | one request outstanding, waiting for imem_rvalid
module fetch_controller
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [DATA_WIDTH-1:0]        imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [31:0]                  instr_pc,
  output logic                         instr_is_compressed,
  output logic                         misalign_err
);

  fetch_state_type state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] instr_pc_q;
  logic        kill_q;
  logic        skip_lo_q;

  logic [1:0]  count;
  logic [31:0] head;
  logic [1:0]  pop_cnt;
  logic [1:0]  push_cnt;
  logic [1:0]  count_after_pop;
  logic        head_rvc;
  logic        redirect_bad;
  logic        redirect_take;
  logic        accept;
  logic        rsp;

`ifdef COMPRESSED_EN
  localparam bit C_EN = 1'b1;
  assign redirect_bad = 1'b0;
  assign misalign_err = 1'b0;
`else
  localparam bit C_EN = 1'b0;
  logic misalign_q;

  assign redirect_bad = redirect_pc[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= redirect_valid & redirect_bad;
  end

  assign misalign_err = misalign_q;
`endif

  assign redirect_take = redirect_valid && !redirect_bad;
  assign head_rvc      = C_EN && is_rvc(head[15:0]);

  assign instr_valid         = (count >= 2'd2) || (count == 2'd1 && head_rvc);
  assign instr_out           = !instr_valid ? '0 : head_rvc ? {16'h0, head[15:0]} : head;
  assign instr_is_compressed = instr_valid && head_rvc;
  assign instr_pc            = instr_pc_q;

  assign pop_cnt         = (instr_valid && instr_ready && !redirect_take) ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign count_after_pop = count - pop_cnt;

  // Request address is not presented in a redirect cycle: fetch_pc is about to change.
  assign imem_req  = (state_q == REQ) && (count_after_pop <= 2'd1) && !redirect_take;
  assign imem_addr = imem_req ? fetch_pc_q : 32'h0;
  assign accept    = imem_req && imem_ready;
  assign rsp       = (state_q == WAIT) && imem_rvalid;

  assign push_cnt = (rsp && !kill_q && !redirect_take) ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (accept) state_d = WAIT;
      WAIT: if (rsp) state_d = ((count_after_pop + push_cnt) <= 2'd1) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_take) state_d = (state_q == WAIT && !imem_rvalid) ? WAIT : REQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      skip_lo_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (redirect_take)  fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      else if (accept)    fetch_pc_q <= fetch_pc_q + 32'd4;

      if (redirect_take)          instr_pc_q <= redirect_pc;
      else if (pop_cnt != 2'd0)   instr_pc_q <= instr_pc_q + {29'd0, pop_cnt, 1'b0};

      // Response already in flight at redirect time belongs to the old stream.
      if (redirect_take && state_q == WAIT && !imem_rvalid) kill_q <= 1'b1;
      else if (rsp)                                         kill_q <= 1'b0;

      if (redirect_take)         skip_lo_q <= C_EN & redirect_pc[1];
      else if (push_cnt != 2'd0) skip_lo_q <= 1'b0;
    end
  end

  parcel_buffer u_parcel_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_take),
    .push_cnt  (push_cnt),
    .push_data (imem_rdata),
    .pop_cnt   (pop_cnt),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: address-keyed memory model plus a program-order reference
// stream (expected instruction at each PC) checked at every decode handshake.
module tb_fetch_controller;
  import common::*;

`ifdef COMPRESSED_EN
  localparam bit C_EN = 1'b1;
`else
  localparam bit C_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ready          (imem_ready),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_out           (instr_out),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed),
    .misalign_err        (misalign_err)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_pc;
  bit          pend;
  logic [31:0] pend_addr;
  int          dly;
  bit          exp_iv_low;
  bit          exp_mis;
  int          n_cons;
  int          n_acc;
  logic [31:0] last_acc_addr;
  logic [31:0] first_cons_pc;
  int          k_rdy, k_irdy, k_redir, k_dly;
  bit          f_rd;
  logic [31:0] f_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = a * 32'h9E37_79B1 + 32'h7F4A_7C15;
    if (C_EN) begin
      case (a)
        32'h0:   return 32'h4505_4501;
        32'h4:   return 32'h0093_4509;
        32'h8:   return 32'h4511_0012;
        default: return w;
      endcase
    end
    if (a == 32'h0) return 32'h0041_0113;
    return {w[31:2], 2'b11};
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] p);
    logic [31:0] w;
    w = mem({p[31:2], 2'b00});
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic expect_at(input logic [31:0] p, output logic [31:0] ins,
                           output logic comp, output logic [31:0] len);
    logic [15:0] h0;
    h0 = hw(p);
    if (!C_EN) begin
      ins = mem({p[31:2], 2'b00}); comp = 1'b0; len = 32'd4;
    end else if (h0[1:0] != 2'b11) begin
      ins = {16'h0, h0}; comp = 1'b1; len = 32'd2;
    end else begin
      ins = {hw(p + 32'd2), h0}; comp = 1'b0; len = 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 7) << 1);
    else                           t = $urandom_range(0, 511) << 1;
    if (!C_EN && $urandom_range(0, 3) != 0) t[1] = 1'b0;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_checks();
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_is_compressed", instr_is_compressed, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_instr_pc", instr_pc, RST_PC);
  endtask

  // One clock: drive at negedge, sample 1 ns later, update reference, advance to next negedge.
  task automatic cyc();
    logic [31:0] e_ins, e_len;
    logic        e_c;
    bit          eff, acc, cons, rv;
    rv = pend && dly == 0;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem(pend_addr) : $urandom();
    imem_ready  = $urandom_range(0, 99) < k_rdy;
    instr_ready = $urandom_range(0, 99) < k_irdy;
    if (f_rd) begin
      redirect_valid = 1'b1; redirect_pc = f_pc; f_rd = 1'b0;
    end else if ($urandom_range(0, 999) < k_redir) begin
      redirect_valid = 1'b1; redirect_pc = rand_target();
    end else begin
      redirect_valid = 1'b0; redirect_pc = $urandom();
    end
    #1;
    eff  = redirect_valid && (C_EN || !redirect_pc[1]);
    acc  = imem_req && imem_ready;
    cons = instr_valid && instr_ready && !eff;
    check("misalign_err", misalign_err, exp_mis);
    if (exp_iv_low) check("valid_after_redirect", instr_valid, 0);
    if (imem_req) begin
      check("addr_align", imem_addr[1:0], 0);
      check("one_outstanding", pend, 0);
    end
    if (cons) begin
      expect_at(m_pc, e_ins, e_c, e_len);
      if (n_cons == 0) first_cons_pc = instr_pc;
      check("instr_pc", instr_pc, m_pc);
      check("instr_out", instr_out, e_ins);
      check("instr_is_compressed", instr_is_compressed, e_c);
      m_pc += e_len;
      n_cons++;
    end
    exp_mis    = redirect_valid && !C_EN && redirect_pc[1];
    exp_iv_low = eff;
    if (eff) m_pc = redirect_pc;
    if (rv) pend = 1'b0;
    else if (pend) dly--;
    if (acc) begin
      pend = 1'b1; pend_addr = imem_addr; dly = $urandom_range(0, k_dly);
      n_acc++; last_acc_addr = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e_ins, e_len;
    logic        e_c;

    rst_n = 1'b0;
    pend = 1'b0; dly = 0; pend_addr = '0; m_pc = RST_PC;
    exp_mis = 1'b0; exp_iv_low = 1'b0; f_rd = 1'b0; f_pc = '0;
    k_rdy = 100; k_irdy = 100; k_redir = 0; k_dly = 0;
    n_cons = 0; n_acc = 0; last_acc_addr = 32'hFFFF_FFFF; first_cons_pc = 32'hFFFF_FFFF;
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();

    // Reset release: first fetch at RESET_PC, first instructions in program order
    rst_n = 1'b1;
    for (int i = 0; i < 10 && n_acc == 0; i++) cyc();
    check("first_fetch_addr", last_acc_addr, RST_PC);
    for (int i = 0; i < 20 && n_cons < 2; i++) cyc();
    check("first_two_instrs", 32'(n_cons >= 2), 1);
    check("first_instr_pc", first_cons_pc, RST_PC);

    // Redirect while a response is outstanding: stale data must be dropped
    k_dly = 2;
    for (int i = 0; i < 40 && !(pend && dly >= 1); i++) cyc();
    check("reached_wait", 32'(pend && dly >= 1), 1);
    f_rd = 1'b1; f_pc = C_EN ? 32'h0000_0102 : 32'h0000_0100;
    n_acc = 0; n_cons = 0; last_acc_addr = 32'hFFFF_FFFF; first_cons_pc = 32'hFFFF_FFFF;
    cyc();
    for (int i = 0; i < 20 && n_acc == 0; i++) cyc();
    check("redirect_fetch_addr", last_acc_addr, 32'h0000_0100);
    for (int i = 0; i < 20 && n_cons == 0; i++) cyc();
    check("redirect_first_pc", first_cons_pc, f_pc);

    // Decoder stalls for 5 cycles with a (possibly straddling) 32-bit instruction at head
    k_dly = 0; k_irdy = 0;
    f_rd = 1'b1; f_pc = C_EN ? 32'h0000_0006 : 32'h0000_0008;
    cyc();
    for (int i = 0; i < 20 && !instr_valid; i++) cyc();
    check("hold_reached", instr_valid, 1);
    expect_at(f_pc, e_ins, e_c, e_len);
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_valid", instr_valid, 1);
      check("hold_out", instr_out, e_ins);
      check("hold_pc", instr_pc, f_pc);
    end
    check("hold_no_request", n_acc, 0);

    // Redirect to a halfword-aligned target
    k_irdy = 100;
    f_rd = 1'b1; f_pc = 32'h0000_0202;
    cyc();
    check("misalign_pulse", misalign_err, 32'(!C_EN));
    cyc();
    check("misalign_one_cycle", misalign_err, 0);

    // Fetch address wraps past 2^32
    f_rd = 1'b1; f_pc = 32'hFFFF_FFF8;
    n_acc = 0; last_acc_addr = 32'hFFFF_FFFF;
    cyc();
    for (int i = 0; i < 40 && n_acc < 3; i++) cyc();
    check("wrap_fetch_addr", last_acc_addr, 32'h0000_0000);

    // Random traffic
    k_rdy = 70; k_irdy = 70; k_redir = 30; k_dly = 3;
    n_cons = 0;
    repeat (3000) cyc();
    check("random_progress", 32'(n_cons > 200), 1);

    // Reset asserted while a response is outstanding
    k_redir = 0; k_rdy = 100;
    for (int i = 0; i < 40 && !(pend && dly >= 1); i++) cyc();
    check("wait_before_reset", 32'(pend && dly >= 1), 1);
    #2 rst_n = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem(pend_addr);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    reset_checks();
    m_pc = RST_PC; exp_mis = 1'b0; exp_iv_low = 1'b0;
    // A late response in the first post-reset cycle must be ignored
    pend = 1'b1; dly = 0; pend_addr = 32'h0000_0040;
    rst_n = 1'b1;
    n_acc = 0; last_acc_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10 && n_acc == 0; i++) cyc();
    check("post_reset_fetch_addr", last_acc_addr, RST_PC);
    n_cons = 0; first_cons_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && n_cons == 0; i++) cyc();
    check("post_reset_first_pc", first_cons_pc, RST_PC);

    k_redir = 30; k_rdy = 60; k_irdy = 60;
    repeat (500) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1, meaning an instruction-memory read request is valid.
REQ-005 The block SHALL have port imem_addr, output, 32, the word-aligned read address, with bits [1:0] always 0.
REQ-006 The block SHALL have port imem_ready, input, 1; a request is accepted in a cycle where imem_req and imem_ready are both high.
REQ-007 The block SHALL have port imem_rvalid, input, 1, meaning read data is valid, at least 1 cycle after acceptance.
REQ-008 The block SHALL have port imem_rdata, input, 32, the read word, little-endian halfwords.
REQ-009 The block SHALL have port redirect_valid, input, 1, a branch/JAL/JALR target request.
REQ-010 The block SHALL have port redirect_pc, input, 32, the target address.
REQ-011 The block SHALL have port instr_valid, output, 1, meaning an instruction is presented to the decoder.
REQ-012 The block SHALL have port instr_ready, input, 1, meaning the decoder consumes the instruction.
REQ-013 The block SHALL have port instr_out, output, INSTRUCTION_WIDTH; a compressed parcel is placed in bits [15:0] with bits [31:16] zero.
REQ-014 The block SHALL have port instr_pc, output, 32, the address of instr_out.
REQ-015 The block SHALL have port instr_is_compressed, output, 1, high when instr_out[1:0] != 2'b11.
REQ-016 The block SHALL have port misalign_err, output, 1, a one-cycle pulse on an illegal redirect target.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, REQ and WAIT; reset enters IDLE, and IDLE moves to REQ unconditionally on the next cycle.
REQ-018 REQ SHALL hold imem_req high with imem_addr = fetch_pc until acceptance, then go to WAIT; WAIT SHALL go to REQ or IDLE on imem_rvalid.
REQ-019 At most one request SHALL be outstanding.
REQ-020 A new request SHALL be issued only when the parcel buffer count, after this cycle's pop, is <= 1.
REQ-021 The parcel buffer SHALL be a 3-entry halfword FIFO whose count ranges 0..3.
REQ-022 A response SHALL push 2 halfwords, or only the upper halfword when it is the first response after a redirect with redirect_pc[1]=1.
REQ-023 fetch_pc SHALL increment by 4 on each acceptance and SHALL wrap modulo 2^32.
REQ-024 instr_valid SHALL be high when count >= 2, or when count == 1 and the head parcel [1:0] != 2'b11.
REQ-025 instr_valid SHALL be combinational from buffer state only and SHALL NOT depend on instr_ready.
REQ-026 On instr_valid and instr_ready, the block SHALL pop 1 halfword if compressed, else 2, and instr_pc SHALL advance by 2 or 4.
REQ-027 A push and a pop in the same cycle SHALL both take effect.
REQ-028 On redirect_valid, the block SHALL flush the buffer, drop any pop or push that cycle, and set fetch_pc = redirect_pc & ~3 and instr_pc = redirect_pc.
REQ-029 After a redirect, the FSM SHALL go to REQ, except when a request is outstanding, in which case it SHALL stay in WAIT.
REQ-030 The response to a request outstanding at redirect time SHALL be discarded via a kill flag.
REQ-031 instr_valid SHALL be low in the cycle after any redirect.

Reset
REQ-032 While rst_n is low, the outputs SHALL be imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_is_compressed=0 and misalign_err=0, with instr_pc=RESET_PC.
REQ-033 While rst_n is low, internal state SHALL be fetch_pc=RESET_PC, buffer count=0, kill=0 and FSM=IDLE.
REQ-034 When reset asserts mid-transaction, the block SHALL abandon any outstanding response and SHALL ignore imem_rvalid until its own next accepted request.

Configuration
REQ-035 With COMPRESSED_EN defined, the block SHALL support halfword-aligned PCs and 16-bit parcels as in REQ-021..REQ-026.
REQ-036 Without COMPRESSED_EN, the buffer SHALL be one 32-bit entry, instr_is_compressed SHALL be tied to 0, and every pop SHALL be 4 bytes.
REQ-037 Without COMPRESSED_EN, a redirect with redirect_pc[1]=1 SHALL be ignored and SHALL pulse misalign_err for one cycle.
REQ-038 With COMPRESSED_EN defined, misalign_err SHALL be tied to 0.

Structure
REQ-039 INSTRUCTION_WIDTH and DATA_WIDTH SHALL come from package common.
REQ-040 The new typedef fetch_state_type {IDLE, REQ, WAIT} SHALL be added to package common.
REQ-041 The parcel buffer SHALL be a sub-module named parcel_buffer, with push count 0/1/2, pop count 0/1/2, flush, and head 32-bit peek.

Verification
REQ-042 Reset release with imem_ready=1 and rvalid 1 cycle later with 32'h0041_0113 -> imem_addr=0, instr_valid with instr_out=32'h0041_0113, instr_pc=0, instr_is_compressed=0.
REQ-043 Word 32'h4505_4501 (two C.LI), instr_ready=1 -> two consecutive instrs 16'h4501 at pc 0 and 16'h4505 at pc 2, both with instr_is_compressed=1.
REQ-044 Redirect to 32'h0000_0102 while a request is in WAIT -> stale response dropped, next imem_addr=32'h100, first instr_pc=32'h102 from the upper halfword.
REQ-045 A 32-bit instruction straddling words 0x4/0x8 with instr_ready=0 for 5 cycles -> instr_valid held, instr_out stable, count never > 3, no extra request.
REQ-046 Without COMPRESSED_EN, redirect to 32'h0000_0202 -> misalign_err=1 for one cycle, fetch continues sequentially.
REQ-047 rst_n asserted while in WAIT, with rvalid arriving during reset -> all outputs at reset values, first post-reset imem_addr=RESET_PC.
